// File: rtl/controlador_exibicao.sv
// rtl/controlador_exibicao.sv - steps through a stored LED sequence with timed on/off phases
module controlador_exibicao #(
  parameter int T_ON  = 1000,
  parameter int T_OFF = 500
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       parar,
  input  logic [3:0] limite,
  input  logic [3:0] dado_memoria,
  output logic [3:0] endereco,
  output logic [3:0] leds,
  output logic       ocupado,
  output logic       pronto,
  output logic [3:0] db_estado
);

  localparam logic [3:0] INICIAL = 4'd0;
  localparam logic [3:0] PREPARA = 4'd1;
  localparam logic [3:0] ACENDE  = 4'd2;
  localparam logic [3:0] APAGA   = 4'd3;
  localparam logic [3:0] PROXIMO = 4'd4;
  localparam logic [3:0] FIM     = 4'd5;

  localparam logic [15:0] ULT_ON  = 16'(T_ON - 1);
  localparam logic [15:0] ULT_OFF = 16'(T_OFF - 1);

  logic [3:0]  estado, estado_prox;
  logic [15:0] timer;
  logic [3:0]  limite_reg;
  logic        fim_on, fim_off;

  assign fim_on  = (timer == ULT_ON);
  assign fim_off = (timer == ULT_OFF);

  always_ff @(posedge clock) begin
    if (reset) estado <= INICIAL;
    else       estado <= estado_prox;
  end

  always_comb begin
    estado_prox = INICIAL;
    case (estado)
      INICIAL: estado_prox = iniciar ? PREPARA : INICIAL;
      PREPARA: estado_prox = ACENDE;
      ACENDE:  estado_prox = fim_on ? APAGA : ACENDE;
      APAGA: begin
        if (!fim_off)                    estado_prox = APAGA;
        else if (endereco == limite_reg) estado_prox = FIM;
        else                             estado_prox = PROXIMO;
      end
      PROXIMO: estado_prox = ACENDE;
      FIM:     estado_prox = INICIAL;
      default: estado_prox = INICIAL;
    endcase
    // Abort wins over start and over timer expiry.
    if (parar) estado_prox = INICIAL;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      timer      <= 16'd0;
      endereco   <= 4'd0;
      limite_reg <= 4'd0;
    end else begin
      // Timer only runs while a timed phase continues; any transition clears it.
      if ((estado_prox == estado) && (estado == ACENDE || estado == APAGA))
        timer <= timer + 16'd1;
      else
        timer <= 16'd0;
      if (estado == PREPARA && estado_prox == ACENDE) begin
        endereco   <= 4'd0;
        limite_reg <= limite;
      end else if (estado == PROXIMO && estado_prox == ACENDE) begin
        endereco <= endereco + 4'd1;
      end
    end
  end

  always_comb begin
    leds      = 4'd0;
    ocupado   = 1'b1;
    pronto    = 1'b0;
    db_estado = estado;
    case (estado)
      INICIAL: ocupado = 1'b0;
      ACENDE:  leds    = dado_memoria;
      FIM:     pronto  = 1'b1;
      default: ;
    endcase
  end

endmodule
